audio_mix: RTL
==============

AUDIO_MIX -- requirements
Module: audio_mix

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of stereo sources mixed (1..16).
REQ-002 SHALL have parameter IN_W, default 16, signed two's-complement source sample width.
REQ-003 SHALL have parameter OUT_W, default 24, signed output sample width (OUT_W >= IN_W).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port next_sample  input  1  one-cycle pulse starting a mix pass.
REQ-007 SHALL have port src_left  input  NUM_SRC*IN_W  left samples; source k at bits [k*IN_W +: IN_W].
REQ-008 SHALL have port src_right  input  NUM_SRC*IN_W  right samples, same packing.
REQ-009 SHALL have port src_vol  input  NUM_SRC*5  per-source gain; source k at [k*5 +: 5].
REQ-010 SHALL have port master_vol  input  5  master gain.
REQ-011 SHALL have port left_data  output  OUT_W  mixed left sample.
REQ-012 SHALL have port right_data  output  OUT_W  mixed right sample.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse when left_data/right_data update.
REQ-014 SHALL have port busy  output  1  high while a pass is in progress.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when next_sample arrives while busy.

Function
REQ-016 SHALL clamp any gain value above 16 to 16; gain g means multiply by g/16 (0 = mute, 16 = unity).
REQ-017 SHALL run FSM IDLE -> ACC -> SCALE -> OUT -> IDLE.
REQ-018 SHALL, in IDLE on next_sample, snapshot all src_left, src_right, src_vol and master_vol, clear both accumulators, enter ACC; busy high from the following cycle.
REQ-019 SHALL in ACC add sample*gain for one source per cycle, source 0 first, both channels in parallel, taking exactly NUM_SRC cycles.
REQ-020 SHALL size accumulators IN_W+5+clog2(NUM_SRC)+1 bits so no intermediate overflow occurs.
REQ-021 SHALL in SCALE compute acc*master_gain arithmetically shifted right 8, then shift left by OUT_W-IN_W.
REQ-022 SHALL in OUT saturate the scaled value to signed OUT_W (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)), register it to left_data/right_data, pulse out_valid, return to IDLE.
REQ-023 SHALL assert out_valid exactly NUM_SRC+2 cycles after the cycle next_sample is sampled in IDLE.
REQ-024 SHALL hold left_data/right_data stable between out_valid pulses.
REQ-025 SHALL ignore next_sample while busy (pass not restarted, snapshot unchanged) and pulse overrun in that cycle.
REQ-026 SHALL not sample source inputs outside the REQ-018 snapshot cycle; input changes mid-pass do not affect the result.

Reset
REQ-027 SHALL, when rst_n is low at a clock edge, force FSM to IDLE, accumulators and snapshot to 0, left_data/right_data to 0, out_valid/busy/overrun to 0.
REQ-028 SHALL abort a pass in progress on reset with no out_valid pulse; next_sample coincident with reset is ignored.

Configuration
REQ-029 SHALL, with macro AUDIO_MIX_CLIP_FLAG_EN defined, add outputs clip_left and clip_right (1 bit each), set sticky when REQ-022 saturation occurs on that channel, cleared by reset or by input clip_clr (1 bit, clears in the cycle it is high; a simultaneous set wins).
REQ-030 SHALL, without AUDIO_MIX_CLIP_FLAG_EN, omit clip_left, clip_right and clip_clr entirely with all other behaviour identical.

Verification (NUM_SRC=4, IN_W=16, OUT_W=24)
REQ-031 SHALL cover: src0 L=16'h4000, vol 16, others 0, master 16, pulse next_sample -> out_valid 6 cycles later, left_data=24'h400000, right_data=0.
REQ-032 SHALL cover: all four L=16'h7FFF, R=16'h8000, all vol 16, master 16 -> left_data=24'h7FFFFF, right_data=24'h800000, clip_left and clip_right set (macro defined).
REQ-033 SHALL cover: src0 L=16'h4000 vol 8, master 31 (clamped to 16) -> left_data=24'h200000.
REQ-034 SHALL cover: next_sample again 2 cycles after start -> overrun pulse in that cycle, single out_valid at cycle 6, result from first snapshot.
REQ-035 SHALL cover: rst_n low at cycle 3 of a pass -> no out_valid, outputs 0, busy 0; next pass after release produces correct result.
REQ-036 SHALL cover: change src_left inputs during ACC -> output equals value computed from the snapshot.

Source files
------------

// File: rtl/audio_mix.sv
// Stereo mixer: NUM_SRC sources, per-source and master 0..16/16 gain, saturated OUT_W output.
// Define AUDIO_MIX_CLIP_FLAG_EN to add sticky clip_left/clip_right flags with a clip_clr input.

module audio_mix_chan #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int ACC_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc_en,
    input  logic             load,
    input  logic [IN_W-1:0]  sample,
    input  logic [4:0]       gain,
    input  logic [4:0]       mgain,
    output logic [OUT_W-1:0] data,
    output logic             sat
);
    localparam int PW = ACC_W + 6;
    localparam int SH = OUT_W - IN_W;
    localparam int EW = PW + SH;
    localparam logic signed [EW-1:0] MAXV = EW'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [IN_W+5:0]  term;
    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    prod, shr;
    logic signed [EW-1:0]    ext;
    logic                    sat_hi, sat_lo;
    logic [OUT_W-1:0]        sat_val;

    always_comb begin
        term    = (IN_W+6)'($signed(sample)) * (IN_W+6)'($signed({1'b0, gain}));
        prod    = PW'(acc) * PW'($signed({1'b0, mgain}));
        shr     = prod >>> 8;
        ext     = EW'(shr) <<< SH;
        sat_hi  = ext > MAXV;
        sat_lo  = ext < MINV;
        sat_val = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                  sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : ext[OUT_W-1:0];
        sat     = load & (sat_hi | sat_lo);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            data <= '0;
        end else begin
            if (clr)         acc <= '0;
            else if (acc_en) acc <= acc + ACC_W'(term);
            if (load)        data <= sat_val;
        end
    end
endmodule

module audio_mix #(
    parameter int NUM_SRC = 2,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    next_sample,
    input  logic [NUM_SRC*IN_W-1:0] src_left,
    input  logic [NUM_SRC*IN_W-1:0] src_right,
    input  logic [NUM_SRC*5-1:0]    src_vol,
    input  logic [4:0]              master_vol,
    output logic [OUT_W-1:0]        left_data,
    output logic [OUT_W-1:0]        right_data,
    output logic                    out_valid,
    output logic                    busy,
`ifdef AUDIO_MIX_CLIP_FLAG_EN
    input  logic                    clip_clr,
    output logic                    clip_left,
    output logic                    clip_right,
`endif
    output logic                    overrun
);
    localparam int ACC_W = IN_W + 5 + $clog2(NUM_SRC) + 1;
    localparam int CNT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;
    state_t state, state_nxt;

    logic [NUM_SRC-1:0][IN_W-1:0] snap_l, snap_r;
    logic [NUM_SRC-1:0][4:0]      snap_vol, vol_clamped;
    logic [4:0]                   snap_mvol;
    logic [CNT_W-1:0]             idx;
    logic                         start, sat_l, sat_r;

    function automatic logic [4:0] clamp16(input logic [4:0] g);
        return (g > 5'd16) ? 5'd16 : g;
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_clamp
        assign vol_clamped[k] = clamp16(src_vol[k*5 +: 5]);
    end

    assign start = (state == IDLE) & next_sample;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (next_sample) state_nxt = ACC;
            ACC:     if (idx == LAST) state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == OUT);
        overrun   = rst_n & busy & next_sample;
    end

    // The only place source inputs are sampled; everything downstream runs from the snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_l    <= '0;
            snap_r    <= '0;
            snap_vol  <= '0;
            snap_mvol <= '0;
            idx       <= '0;
        end else if (start) begin
            snap_l    <= src_left;
            snap_r    <= src_right;
            snap_vol  <= vol_clamped;
            snap_mvol <= clamp16(master_vol);
            idx       <= '0;
        end else if (state == ACC) begin
            idx <= idx + 1'b1;
        end
    end

    audio_mix_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_chan_l (
        .clk(clk), .rst_n(rst_n), .clr(start), .acc_en(state == ACC), .load(state == SCALE),
        .sample(snap_l[idx]), .gain(snap_vol[idx]), .mgain(snap_mvol),
        .data(left_data), .sat(sat_l)
    );

    audio_mix_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_chan_r (
        .clk(clk), .rst_n(rst_n), .clr(start), .acc_en(state == ACC), .load(state == SCALE),
        .sample(snap_r[idx]), .gain(snap_vol[idx]), .mgain(snap_mvol),
        .data(right_data), .sat(sat_r)
    );

`ifdef AUDIO_MIX_CLIP_FLAG_EN
    // Set has priority over clear so a clip landing on a clear cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_left  <= 1'b0;
            clip_right <= 1'b0;
        end else begin
            if (sat_l)         clip_left  <= 1'b1;
            else if (clip_clr) clip_left  <= 1'b0;
            if (sat_r)         clip_right <= 1'b1;
            else if (clip_clr) clip_right <= 1'b0;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_l ^ sat_r;
`endif
endmodule
